// File: rtl/cpu_pkg.sv
// Shared encodings for the MIPS core: ALU control codes, ALUOp and funct values,
// and the operand forward-select encoding used by the ID/EX stage.
package cpu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_OR    = 2'b11;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;
    localparam logic [5:0] FUNCT_NOR = 6'b100111;

    typedef enum logic [1:0] {
        FWD_REG   = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10
    } fwd_sel_e;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational ALUOp/funct to 4-bit ALU control decode; flags unknown R-type funct.
module alu_ctrl_decode
    import cpu_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output logic [3:0] alu_control,
    output logic       illegal
);

    always_comb begin
        alu_control = ALU_ADD;
        illegal     = 1'b0;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_OR:  alu_control = ALU_OR;
            default: begin
                case (funct)
                    FUNCT_ADD: alu_control = ALU_ADD;
                    FUNCT_SUB: alu_control = ALU_SUB;
                    FUNCT_AND: alu_control = ALU_AND;
                    FUNCT_OR:  alu_control = ALU_OR;
                    FUNCT_SLT: alu_control = ALU_SLT;
                    FUNCT_NOR: alu_control = ALU_NOR;
                    default:   illegal     = 1'b1;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with ALU operand forwarding and load-use hazard detection.
// Define ID_EX_FORWARD_EN to build the EX/MEM and MEM/WB forwarding muxes.
module id_ex_stage
    import cpu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [1:0]        id_alu_op,
    input  logic [5:0]        id_funct,
    input  logic              id_alu_src,
    input  logic              id_reg_dst,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              id_mem_to_reg,
    input  logic              exmem_reg_write,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic [DATA_W-1:0] exmem_result,
    input  logic              memwb_reg_write,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic [DATA_W-1:0] memwb_data,
    output logic [DATA_W-1:0] alu_data1,
    output logic [DATA_W-1:0] alu_data2,
    output logic [3:0]        alu_control,
    output logic [DATA_W-1:0] ex_store_data,
    output logic [REG_AW-1:0] ex_write_reg,
    output logic              ex_valid,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_mem_to_reg,
    output logic              ex_illegal,
    output logic              hazard_stall
);

    logic [DATA_W-1:0] rs_data_q, rt_data_q, imm_q;
    logic [REG_AW-1:0] rs_q, rt_q, rd_q;
    logic [1:0]        alu_op_q;
    logic [5:0]        funct_q;
    logic              valid_q, alu_src_q, reg_dst_q, reg_write_q;
    logic              mem_read_q, mem_write_q, mem_to_reg_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || flush) begin
            valid_q      <= 1'b0;
            rs_data_q    <= '0;
            rt_data_q    <= '0;
            imm_q        <= '0;
            rs_q         <= '0;
            rt_q         <= '0;
            rd_q         <= '0;
            alu_op_q     <= '0;
            funct_q      <= '0;
            alu_src_q    <= 1'b0;
            reg_dst_q    <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
        end else if (!stall) begin
            valid_q      <= id_valid;
            rs_data_q    <= id_rs_data;
            rt_data_q    <= id_rt_data;
            imm_q        <= id_imm;
            rs_q         <= id_rs;
            rt_q         <= id_rt;
            rd_q         <= id_rd;
            alu_op_q     <= id_alu_op;
            funct_q      <= id_funct;
            alu_src_q    <= id_alu_src;
            reg_dst_q    <= id_reg_dst;
            // A non-instruction in ID must never produce side effects downstream.
            reg_write_q  <= id_reg_write & id_valid;
            mem_read_q   <= id_mem_read & id_valid;
            mem_write_q  <= id_mem_write & id_valid;
            mem_to_reg_q <= id_mem_to_reg;
        end
    end

    logic [DATA_W-1:0] rs_fwd, rt_fwd;

`ifdef ID_EX_FORWARD_EN
    function automatic fwd_sel_e fwd_select(input logic [REG_AW-1:0] src);
        if (exmem_reg_write && exmem_rd != '0 && exmem_rd == src)
            return FWD_EXMEM;
        else if (memwb_reg_write && memwb_rd != '0 && memwb_rd == src)
            return FWD_MEMWB;
        else
            return FWD_REG;
    endfunction

    fwd_sel_e rs_sel, rt_sel;
    assign rs_sel = fwd_select(rs_q);
    assign rt_sel = fwd_select(rt_q);

    always_comb begin
        rs_fwd = rs_data_q;
        rt_fwd = rt_data_q;
        case (rs_sel)
            FWD_EXMEM: rs_fwd = exmem_result;
            FWD_MEMWB: rs_fwd = memwb_data;
            default:   rs_fwd = rs_data_q;
        endcase
        case (rt_sel)
            FWD_EXMEM: rt_fwd = exmem_result;
            FWD_MEMWB: rt_fwd = memwb_data;
            default:   rt_fwd = rt_data_q;
        endcase
    end
`else
    logic unused_fwd_inputs;
    assign unused_fwd_inputs = ^{exmem_result, memwb_reg_write, memwb_rd, memwb_data};
    assign rs_fwd = rs_data_q;
    assign rt_fwd = rt_data_q;
`endif

    assign alu_data1     = rs_fwd;
    assign alu_data2     = alu_src_q ? imm_q : rt_fwd;
    assign ex_store_data = rt_fwd;
    assign ex_write_reg  = reg_dst_q ? rd_q : rt_q;
    assign ex_valid      = valid_q;
    assign ex_reg_write  = reg_write_q;
    assign ex_mem_read   = mem_read_q;
    assign ex_mem_write  = mem_write_q;
    assign ex_mem_to_reg = mem_to_reg_q;

    logic illegal_funct;

    alu_ctrl_decode u_alu_ctrl_decode (
        .alu_op      (alu_op_q),
        .funct       (funct_q),
        .alu_control (alu_control),
        .illegal     (illegal_funct)
    );

    assign ex_illegal = illegal_funct & valid_q;

    logic load_use;
    assign load_use = valid_q & mem_read_q & (rt_q != '0) &
                      ((rt_q == id_rs) | (rt_q == id_rt));

`ifdef ID_EX_FORWARD_EN
    assign hazard_stall = load_use;
`else
    // Without forwarding, any in-flight producer of an ID source must drain first.
    function automatic logic src_pending(input logic [REG_AW-1:0] src);
        return (src != '0) &&
               ((reg_write_q && src == ex_write_reg) ||
                (exmem_reg_write && src == exmem_rd));
    endfunction

    assign hazard_stall = load_use |
                          (id_valid & (src_pending(id_rs) | src_pending(id_rt)));
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage; expected values are hand-computed.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, flush, id_valid;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [1:0]  id_alu_op;
    logic [5:0]  id_funct;
    logic        id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
    logic        exmem_reg_write, memwb_reg_write;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] exmem_result, memwb_data;
    logic [31:0] alu_data1, alu_data2, ex_store_data;
    logic [3:0]  alu_control;
    logic [4:0]  ex_write_reg;
    logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
    logic        ex_illegal, hazard_stall;

    int n_checks = 0;
    int n_fail   = 0;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .id_valid(id_valid),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_alu_op(id_alu_op), .id_funct(id_funct),
        .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
        .alu_data1(alu_data1), .alu_data2(alu_data2), .alu_control(alu_control),
        .ex_store_data(ex_store_data), .ex_write_reg(ex_write_reg),
        .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
        .ex_illegal(ex_illegal), .hazard_stall(hazard_stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to 1 time unit past the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_id(input logic v, input logic [31:0] rsd, input logic [31:0] rtd,
                            input logic [31:0] imm, input logic [4:0] rs, input logic [4:0] rt,
                            input logic [4:0] rd, input logic [1:0] op, input logic [5:0] fn,
                            input logic asrc, input logic rdst, input logic rw,
                            input logic mr, input logic mw, input logic m2r);
        id_valid = v; id_rs_data = rsd; id_rt_data = rtd; id_imm = imm;
        id_rs = rs; id_rt = rt; id_rd = rd; id_alu_op = op; id_funct = fn;
        id_alu_src = asrc; id_reg_dst = rdst; id_reg_write = rw;
        id_mem_read = mr; id_mem_write = mw; id_mem_to_reg = m2r;
    endtask

    logic [1:0] t_op  [9];
    logic [5:0] t_fn  [9];
    logic [3:0] t_exp [9];

    initial begin
        t_op  = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10};
        t_fn  = '{6'h00, 6'h00, 6'h00, 6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h27};
        t_exp = '{4'h2, 4'h6, 4'h1, 4'h2, 4'h6, 4'h0, 4'h1, 4'h7, 4'hC};

        rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
        exmem_reg_write = 1'b0; exmem_rd = '0; exmem_result = '0;
        memwb_reg_write = 1'b0; memwb_rd = '0; memwb_data = '0;
        drive_id(0, 0, 0, 0, 0, 0, 0, 2'b00, 6'h00, 0, 0, 0, 0, 0, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        check("reset_valid", 32'(ex_valid), 32'd0);
        check("reset_alu_control", 32'(alu_control), 32'h2);
        check("reset_data1", alu_data1, 32'd0);
        check("reset_hazard", 32'(hazard_stall), 32'd0);

        // R-type add
        drive_id(1, 32'd5, 32'd7, 32'd0, 5'd1, 5'd2, 5'd3, 2'b10, 6'h20, 0, 1, 1, 0, 0, 0);
        tick();
        check("add_data1", alu_data1, 32'd5);
        check("add_data2", alu_data2, 32'd7);
        check("add_ctrl", 32'(alu_control), 32'h2);
        check("add_wreg", 32'(ex_write_reg), 32'd3);
        check("add_valid", 32'(ex_valid), 32'd1);
        check("add_regwrite", 32'(ex_reg_write), 32'd1);

        // Immediate operand selection and ALU control table
        drive_id(1, 32'd5, 32'd7, 32'h1234, 5'd1, 5'd2, 5'd3, 2'b00, 6'h00, 1, 0, 0, 0, 0, 0);
        tick();
        check("imm_data2", alu_data2, 32'h1234);
        check("imm_store", ex_store_data, 32'd7);
        check("imm_wreg_rt", 32'(ex_write_reg), 32'd2);
        for (int i = 0; i < 9; i++) begin
            id_alu_op = t_op[i];
            id_funct  = t_fn[i];
            tick();
            check($sformatf("ctrl_%0d", i), 32'(alu_control), 32'(t_exp[i]));
            check($sformatf("ctrl_legal_%0d", i), 32'(ex_illegal), 32'd0);
        end

        // Forwarding
        drive_id(1, 32'h11, 32'h22, 32'd0, 5'd3, 5'd4, 5'd12, 2'b10, 6'h20, 0, 1, 0, 0, 0, 0);
        tick();
        exmem_reg_write = 1; exmem_rd = 5'd3; exmem_result = 32'hAA;
        memwb_reg_write = 1; memwb_rd = 5'd3; memwb_data = 32'hBB;
        #1;
`ifdef ID_EX_FORWARD_EN
        check("fwd_exmem_wins", alu_data1, 32'hAA);
        check("fwd_no_hazard", 32'(hazard_stall), 32'd0);
        exmem_reg_write = 0;
        #1;
        check("fwd_memwb", alu_data1, 32'hBB);
        memwb_rd = 5'd4;
        #1;
        check("fwd_rt_memwb", ex_store_data, 32'hBB);
        check("fwd_rt_data2", alu_data2, 32'hBB);
        drive_id(1, 32'h55, 32'h66, 32'd0, 5'd0, 5'd0, 5'd12, 2'b10, 6'h20, 0, 1, 0, 0, 0, 0);
        exmem_reg_write = 1; exmem_rd = 5'd0; memwb_rd = 5'd0;
        tick();
        check("fwd_r0_rs", alu_data1, 32'h55);
        check("fwd_r0_rt", ex_store_data, 32'h66);
`else
        check("nofwd_data1", alu_data1, 32'h11);
        check("nofwd_exmem_hazard", 32'(hazard_stall), 32'd1);
        exmem_reg_write = 0;
        #1;
        check("nofwd_data1_memwb", alu_data1, 32'h11);
        check("nofwd_clear_hazard", 32'(hazard_stall), 32'd0);
        drive_id(1, 32'h55, 32'h66, 32'd0, 5'd1, 5'd2, 5'd9, 2'b10, 6'h20, 0, 1, 1, 0, 0, 0);
        tick();
        id_rs = 5'd9;
        #1;
        check("nofwd_ex_hazard", 32'(hazard_stall), 32'd1);
        id_valid = 0;
        #1;
        check("nofwd_ex_hazard_invalid", 32'(hazard_stall), 32'd0);
`endif
        exmem_reg_write = 0; exmem_rd = '0; exmem_result = '0;
        memwb_reg_write = 0; memwb_rd = '0; memwb_data = '0;

        // Load-use: lw with rt=8, next ID instruction reads r8
        drive_id(1, 32'h40, 32'h0, 32'h4, 5'd1, 5'd8, 5'd0, 2'b00, 6'h00, 1, 0, 1, 1, 0, 1);
        tick();
        id_rs = 5'd8; id_rt = 5'd0;
        #1;
        check("lu_memread", 32'(ex_mem_read), 32'd1);
        check("lu_wreg", 32'(ex_write_reg), 32'd8);
        check("lu_hazard", 32'(hazard_stall), 32'd1);
        flush = 1;
        tick();
        flush = 0;
        check("lu_flush_valid", 32'(ex_valid), 32'd0);
        check("lu_flush_regwrite", 32'(ex_reg_write), 32'd0);
        check("lu_flush_hazard", 32'(hazard_stall), 32'd0);

        // Stall holds every field
        drive_id(1, 32'h100, 32'h200, 32'd0, 5'd5, 5'd6, 5'd7, 2'b10, 6'h22, 0, 1, 1, 0, 0, 0);
        tick();
        drive_id(1, 32'h999, 32'h888, 32'h777, 5'd10, 5'd11, 5'd13, 2'b11, 6'h00, 1, 0, 0, 1, 1, 1);
        stall = 1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("stall_data1_%0d", c), alu_data1, 32'h100);
            check($sformatf("stall_data2_%0d", c), alu_data2, 32'h200);
            check($sformatf("stall_ctrl_%0d", c), 32'(alu_control), 32'h6);
            check($sformatf("stall_wreg_%0d", c), 32'(ex_write_reg), 32'd7);
            check($sformatf("stall_memread_%0d", c), 32'(ex_mem_read), 32'd0);
        end
        flush = 1;
        tick();
        stall = 0; flush = 0;
        check("stflush_valid", 32'(ex_valid), 32'd0);
        check("stflush_regwrite", 32'(ex_reg_write), 32'd0);
        check("stflush_memwrite", 32'(ex_mem_write), 32'd0);
        check("stflush_data1", alu_data1, 32'd0);

        // Invalid ID instruction loads with side effects suppressed
        drive_id(0, 32'h3, 32'h4, 32'd0, 5'd1, 5'd2, 5'd3, 2'b00, 6'h00, 0, 1, 1, 1, 1, 0);
        tick();
        check("inv_valid", 32'(ex_valid), 32'd0);
        check("inv_regwrite", 32'(ex_reg_write), 32'd0);
        check("inv_memread", 32'(ex_mem_read), 32'd0);
        check("inv_memwrite", 32'(ex_mem_write), 32'd0);
        check("inv_data1", alu_data1, 32'h3);

        // Illegal funct
        drive_id(1, 32'h1, 32'h2, 32'd0, 5'd1, 5'd2, 5'd3, 2'b10, 6'h3F, 0, 1, 1, 0, 0, 0);
        tick();
        check("illegal_flag", 32'(ex_illegal), 32'd1);
        check("illegal_ctrl", 32'(alu_control), 32'h2);
        id_valid = 0;
        tick();
        check("illegal_invalid", 32'(ex_illegal), 32'd0);

        // Asynchronous reset mid-cycle with valid state held
        drive_id(1, 32'h21, 32'h22, 32'd0, 5'd4, 5'd5, 5'd6, 2'b01, 6'h00, 0, 1, 1, 1, 0, 1);
        tick();
        check("pre_reset_valid", 32'(ex_valid), 32'd1);
        #2;
        rst_n = 0;
        #1;
        check("areset_valid", 32'(ex_valid), 32'd0);
        check("areset_ctrl", 32'(alu_control), 32'h2);
        check("areset_data1", alu_data1, 32'd0);
        check("areset_wreg", 32'(ex_write_reg), 32'd0);
        check("areset_memread", 32'(ex_mem_read), 32'd0);
        check("areset_m2r", 32'(ex_mem_to_reg), 32'd0);
        @(negedge clk);
        rst_n = 1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register of the five-stage MIPS core. Sits directly upstream of the ALU.
- Captures decoded operands and control on each clock.
- In EX, it drives the ALU's data1, data2 and 4-bit ALUControl inputs, applying operand forwarding from EX/MEM and MEM/WB.
- Detects load-use hazards against the instruction it holds and requests a stall of IF/ID.

Parameters:
- DATA_W, 32, datapath width.
- REG_AW, 5, register-index width.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- stall  in  1  hold register contents.
- flush  in  1  load a bubble.
- id_valid  in  1  ID holds a real instruction.
- id_rs_data, id_rt_data  in  32  register-file read data.
- id_imm  in  32  sign-extended immediate.
- id_rs, id_rt, id_rd  in  5  register indices.
- id_alu_op  in  2  main-decoder ALUOp.
- id_funct  in  6  instruction funct field.
- id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg  in  1 each  control bits.
- exmem_reg_write  in  1  EX/MEM writes a register.
- exmem_rd  in  5  EX/MEM destination.
- exmem_result  in  32  EX/MEM ALU result.
- memwb_reg_write  in  1  MEM/WB writes a register.
- memwb_rd  in  5  MEM/WB destination.
- memwb_data  in  32  write-back data.
- alu_data1, alu_data2  out  32  ALU operands.
- alu_control  out  4  ALU operation code.
- ex_store_data  out  32  forwarded rt value, used for sw.
- ex_write_reg  out  5  destination: rd if reg_dst, else rt.
- ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg  out  1 each.
- ex_illegal  out  1  unknown funct with ALUOp=10.
- hazard_stall  out  1  load-use stall request.

Behaviour:
- Register update priority per rising edge: reset > flush > stall > load.
  - flush: valid and all control bits cleared; data and index fields don't-care, implementation clears them.
  - stall: every field holds.
  - load: every id_* field is captured; ex_valid <= id_valid.
- If id_valid=0, the load happens but reg_write, mem_read and mem_write are forced to 0.
- Reset (rst_n low, asynchronous): all registered fields 0. Resulting outputs:
  - ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_illegal, hazard_stall = 0.
  - ex_write_reg = 0, alu_control = 0010, alu_data1 = alu_data2 = ex_store_data = 0.
- Latency: one cycle from ID inputs to EX outputs. All outputs are combinational from registered state plus forwarding inputs; no combinational path from id_* data to outputs.
- Forwarding, per operand (rs, rt):
  - EX/MEM is selected if exmem_reg_write and exmem_rd != 0 and exmem_rd equals the held index.
  - Otherwise MEM/WB is selected under the same conditions with memwb_*.
  - Otherwise the registered data is used.
  - EX/MEM wins when both stages match.
  - Register 0 is never forwarded.
- Operand mapping:
  - alu_data1 = forwarded rs.
  - ex_store_data = forwarded rt.
  - alu_data2 = id_imm (registered) if alu_src, else forwarded rt.
- alu_control decode:
  - ALUOp 00 -> 0010.
  - ALUOp 01 -> 0110.
  - ALUOp 11 -> 0001.
  - ALUOp 10, by funct:
    - 100000 -> 0010.
    - 100010 -> 0110.
    - 100100 -> 0000.
    - 100101 -> 0001.
    - 101010 -> 0111.
    - 100111 -> 1100.
    - Any other funct -> 0010, with ex_illegal = ex_valid.
- hazard_stall = ex_valid & ex_mem_read & (held rt != 0) & (held rt == id_rs | held rt == id_rt).
  - The pipeline controller responds with flush=1 for one cycle.
  - If stall and flush are both asserted, flush wins.
- The register file writes in the first half-cycle, so WB-to-ID needs no handling here.

Optional Feature:
- Macro: ID_EX_FORWARD_EN.
- Defined: forwarding exactly as above.
- Undefined:
  - Forward muxes are removed; operands come straight from the registered data.
  - exmem_* and memwb_* inputs are ignored, except for hazard detection.
  - hazard_stall is also asserted when a valid ID source (non-zero) matches ex_write_reg with ex_reg_write, or matches exmem_rd with exmem_reg_write.

Decomposition:
- Package cpu_pkg holds:
  - ALUControl codes: AND, OR, ADD, SUB, SLT, NOR.
  - ALUOp codes.
  - Funct constants.
  - 2-bit forward-select encoding: REG, EXMEM, MEMWB.
- Sub-module alu_ctrl_decode: combinational ALUOp/funct -> alu_control plus illegal flag.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with valid state loaded -> outputs clear immediately; alu_control=0010.
- R-type add: load id_rs_data=5, id_rt_data=7, ALUOp=10, funct=100000 -> next cycle alu_data1=5, alu_data2=7, alu_control=0010.
- Forward priority: held rs=3; exmem_rd=3, exmem_result=0xAA; memwb_rd=3, memwb_data=0xBB -> alu_data1=0xAA.
  - Clear exmem_reg_write -> 0xBB.
  - Set rs=0 -> registered value.
- Load-use: hold lw with rt=8; id_rs=8 -> hazard_stall=1.
  - Apply flush -> ex_valid=0, ex_reg_write=0, hazard_stall=0.
- Stall vs flush: stall=1 holds all outputs for 3 cycles; stall=1 with flush=1 -> bubble.
- Illegal funct 111111 with ALUOp=10 -> ex_illegal=1, alu_control=0010.
  - Same with ex_valid=0 -> ex_illegal=0.
